// File: rtl/pulse_stretch_if.sv
// Strobe/level bundle between pulse_stretch and its user.
// The master drives the strobes; the slave (pulse_stretch) returns the levels and flags.
interface pulse_stretch_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] pulse_sig;
  logic [WIDTH-1:0] level_sig;
  logic [WIDTH-1:0] drop_sig;
  logic             busy_sig;

  modport master (
    output pulse_sig,
    input  level_sig,
    input  drop_sig,
    input  busy_sig
  );

  modport slave (
    input  pulse_sig,
    output level_sig,
    output drop_sig,
    output busy_sig
  );
endinterface

// File: rtl/pulse_stretch.sv
// Per-channel strobe-to-level stretcher with an optional forced-low cool-down.
// Build option: define PULSE_STRETCH_RETRIG_EN to let strobes during HOLD reload the hold timer.
//
// state | meaning
// IDLE  | level low, next strobe is accepted
// HOLD  | level high, counting down HOLD_CYCLES
// GAP   | level low, counting down GAP_CYCLES, strobes dropped
module pulse_stretch #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  pulse_stretch_if.slave  bus
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_HOLD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] C_GAP  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 0) begin : g_bad_param
    $error("pulse_stretch: HOLD_CYCLES must be >= 1 and GAP_CYCLES >= 0");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           r_state   [WIDTH];
  state_t           w_state_nxt [WIDTH];
  logic [CW-1:0]    r_cnt     [WIDTH];
  logic [CW-1:0]    w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_level_nxt;
  logic [WIDTH-1:0] w_drop_nxt;
  logic             w_busy_nxt;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_drop;
  logic             r_busy;

  always_comb begin
    w_level_nxt = '0;
    w_drop_nxt  = '0;
    w_busy_nxt  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_IDLE: begin
          if (bus.pulse_sig[i]) begin
            w_state_nxt[i] = ST_HOLD;
            w_cnt_nxt[i]   = C_HOLD;
          end
        end
        ST_HOLD: begin
`ifdef PULSE_STRETCH_RETRIG_EN
          if (bus.pulse_sig[i]) begin
            w_cnt_nxt[i] = C_HOLD;
          end else if (r_cnt[i] <= C_ONE) begin
`else
          w_drop_nxt[i] = bus.pulse_sig[i];
          if (r_cnt[i] <= C_ONE) begin
`endif
            if (GAP_CYCLES > 0) begin
              w_state_nxt[i] = ST_GAP;
              w_cnt_nxt[i]   = C_GAP;
            end else begin
              w_state_nxt[i] = ST_IDLE;
              w_cnt_nxt[i]   = '0;
            end
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - C_ONE;
          end
        end
        ST_GAP: begin
          w_drop_nxt[i] = bus.pulse_sig[i];
          if (r_cnt[i] <= C_ONE) begin
            w_state_nxt[i] = ST_IDLE;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - C_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
      // Outputs are registered from the next state so they line up with the state register.
      w_level_nxt[i] = (w_state_nxt[i] == ST_HOLD);
      w_busy_nxt     = w_busy_nxt | (w_state_nxt[i] != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_level <= '0;
      r_drop  <= '0;
      r_busy  <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_level <= w_level_nxt;
      r_drop  <= w_drop_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.level_sig = r_level;
  assign bus.drop_sig  = r_drop;
  assign bus.busy_sig  = r_busy;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed + random bench for pulse_stretch: three instances (HOLD/GAP = 4/2, 4/0, 1/0)
// checked cycle by cycle against an interval-based reference held in a scoreboard queue.
module tb_pulse_stretch;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pulse_stretch_if #(.WIDTH(4)) if_a ();
  pulse_stretch_if #(.WIDTH(4)) if_b ();
  pulse_stretch_if #(.WIDTH(4)) if_c ();

  pulse_stretch #(.WIDTH(4), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  pulse_stretch #(.WIDTH(4), .HOLD_CYCLES(4), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  pulse_stretch #(.WIDTH(4), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave));

`ifdef PULSE_STRETCH_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam int HOLD_P [3] = '{4, 4, 1};
  localparam int GAP_P  [3] = '{2, 0, 0};

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] drp;
    logic       bsy;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  // Each channel's current hold window is cycles m_lo..m_hi, then GAP_P cycles of cool-down.
  int   m_lo [3][4];
  int   m_hi [3][4];

  logic [3:0] o_lvl [3];
  logic [3:0] o_drp [3];
  logic       o_bsy [3];
  assign o_lvl[0] = if_a.level_sig;  assign o_drp[0] = if_a.drop_sig;  assign o_bsy[0] = if_a.busy_sig;
  assign o_lvl[1] = if_b.level_sig;  assign o_drp[1] = if_b.drop_sig;  assign o_bsy[1] = if_b.busy_sig;
  assign o_lvl[2] = if_c.level_sig;  assign o_drp[2] = if_c.drop_sig;  assign o_bsy[2] = if_c.busy_sig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4; i++) begin
        m_lo[d][i] = -1000;
        m_hi[d][i] = -1000;
      end
  endtask

  task automatic model_edge(input int d, input logic [3:0] p);
    exp_t x;
    int   e;
    int   c;
    bit   in_hold;
    bit   in_gap;
    x = '0;
    e = edge_n;
    c = edge_n + 1;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        in_hold = (m_lo[d][i] <= e) && (e <= m_hi[d][i]);
        in_gap  = (m_hi[d][i] < e) && (e <= m_hi[d][i] + GAP_P[d]);
        if (!in_hold && !in_gap) begin
          m_lo[d][i] = e + 1;
          m_hi[d][i] = e + HOLD_P[d];
        end else if (in_hold && RETRIG) begin
          m_hi[d][i] = e + HOLD_P[d];
        end else begin
          x.drp[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (m_lo[d][i] <= c && c <= m_hi[d][i]) x.lvl[i] = 1'b1;
      if (m_lo[d][i] <= c && c <= m_hi[d][i] + GAP_P[d]) x.bsy = 1'b1;
    end
    sb.push_back(x);
  endtask

  task automatic sb_check();
    exp_t x;
    for (int d = 0; d < 3; d++) begin
      x = sb.pop_front();
      chk($sformatf("level d%0d e%0d", d, edge_n), {28'd0, o_lvl[d]}, {28'd0, x.lvl});
      chk($sformatf("drop d%0d e%0d", d, edge_n), {28'd0, o_drp[d]}, {28'd0, x.drp});
      chk($sformatf("busy d%0d e%0d", d, edge_n), {31'd0, o_bsy[d]}, {31'd0, x.bsy});
    end
  endtask

  task automatic step(input logic [3:0] pa, input logic [3:0] pb, input logic [3:0] pc);
    if_a.pulse_sig = pa;
    if_b.pulse_sig = pb;
    if_c.pulse_sig = pc;
    @(posedge clk);
    model_edge(0, pa);
    model_edge(1, pb);
    model_edge(2, pc);
    #1;
    sb_check();
    edge_n++;
  endtask

  task automatic run_to(input int e, input logic [3:0] pa, input logic [3:0] pb, input logic [3:0] pc);
    while (edge_n < e) step(4'd0, 4'd0, 4'd0);
    step(pa, pb, pc);
  endtask

  task automatic do_reset(input string tag);
    if_a.pulse_sig = '0;
    if_b.pulse_sig = '0;
    if_c.pulse_sig = '0;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s level d%0d", tag, d), {28'd0, o_lvl[d]}, 32'd0);
      chk($sformatf("%s drop d%0d", tag, d), {28'd0, o_drp[d]}, 32'd0);
      chk($sformatf("%s busy d%0d", tag, d), {31'd0, o_bsy[d]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    edge_n = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.pulse_sig = '0;
    if_b.pulse_sig = '0;
    if_c.pulse_sig = '0;
    model_reset();
    #12;
    do_reset("reset_init");

    // Basic stretch, GAP drop, retrigger and HOLD=1 boundary in parallel on the three instances.
    run_to(5, 4'd0, 4'd0, 4'b0100);
    step(4'd0, 4'd0, 4'b0100);
    chk("c_boundary_level_c7", {28'd0, o_lvl[2]}, RETRIG ? 32'h4 : 32'h0);
    chk("c_boundary_drop_c7", {28'd0, o_drp[2]}, RETRIG ? 32'h0 : 32'h4);
    run_to(10, 4'b0001, 4'b0010, 4'd0);
    chk("basic_level_c11", {28'd0, o_lvl[0]}, 32'h1);
    run_to(13, 4'd0, 4'b0010, 4'd0);
    chk("retrig_drop_c14", {28'd0, o_drp[1]}, RETRIG ? 32'h0 : 32'h2);
    run_to(15, 4'b0001, 4'd0, 4'd0);
    chk("gap_drop_c16", {28'd0, o_drp[0]}, 32'h1);
    chk("gap_level_c16", {28'd0, o_lvl[0]}, 32'h0);
    chk("gap_busy_c16", {31'd0, o_bsy[0]}, 32'h1);
    run_to(17, 4'b0001, 4'd0, 4'd0);
    run_to(18, 4'd0, 4'd0, 4'd0);
    chk("reaccept_level_c19", {28'd0, o_lvl[0]}, 32'h1);
    run_to(25, 4'd0, 4'd0, 4'd0);

    // All channels held high for ten edges.
    do_reset("reset_held");
    run_to(20, 4'hf, 4'hf, 4'hf);
    for (int e = 21; e <= 29; e++) begin
      step(4'hf, 4'hf, 4'hf);
      if (e == 24) chk("held_drop_c25", {28'd0, o_drp[0]}, 32'hf);
      if (e == 27) chk("held_reaccept_c28", {28'd0, o_lvl[0]}, 32'hf);
    end
    run_to(35, 4'd0, 4'd0, 4'd0);

    // Asynchronous reset in the middle of cycle 12, between clock edges.
    do_reset("reset_pre_async");
    run_to(10, 4'b0001, 4'b0001, 4'b0001);
    run_to(11, 4'd0, 4'd0, 4'd0);
    chk("async_pre_level", {28'd0, o_lvl[0]}, 32'h1);
    #2;
    do_reset("async_mid_hold");
    run_to(2, 4'b0001, 4'b0001, 4'b0001);
    run_to(10, 4'd0, 4'd0, 4'd0);

    for (int n = 0; n < 80; n++) begin
      step(4'($urandom & $urandom), 4'($urandom & $urandom), 4'($urandom & $urandom));
    end
    run_to(edge_n + 8, 4'd0, 4'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
